// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer APB register bank:
//   - register addresses (TDR, TCR, TSR)
//   - TCR writable-bit mask and TSR status bit positions
//   - APB completer FSM state type
//   - helper that packs the status bits into the TSR byte
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

    // TCR bits kept: [7] load, [5] direction, [4] enable, [1:0] clock select
    localparam logic [7:0] TCR_MASK = 8'hB3;

    localparam int OVF = 0;
    localparam int UDF = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    function automatic logic [7:0] tsr_pack(input logic udf, input logic ovf);
        return {6'b0, udf, ovf};
    endfunction

endpackage

// File: rtl/timer_apb_fsm.sv
// ---------------------------------------------------------------------------
// timer_apb_fsm
// APB3 completer handshake with a programmable number of wait states.
// Optional feature macro: TIMER_APB_PSLVERR_EN (drive pslverr on illegal
// addresses; when undefined pslverr is tied low).
//
// Ports:
//   pclk_i, presetn_i   clock, asynchronous active-low reset
//   psel_i, penable_i   APB select / enable
//   pwrite_i            1 = write, 0 = read
//   paddr_i, pwdata_i   APB address and write data
//   pready_o            registered transfer-complete
//   pslverr_o           registered error response (with pready_o)
//   wr_en_o             write commit strobe (the pready cycle)
//   rd_en_o             read-data load strobe (cycle before pready)
//   addr_err_o          current transfer address is outside the bank
//   addr_o, wdata_o     address / write data of the current transfer
// ---------------------------------------------------------------------------
module timer_apb_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [7:0]        pwdata_i,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic              addr_err_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [7:0]        wdata_q;
    logic              pready_q;

    state_t            phase;
    logic              cur_write;
    logic              cur_err;
    logic              finishing;

    // The SETUP phase is recognised in the same cycle the initiator presents
    // it, so pready/prdata can be registered and still land in the first
    // ACCESS cycle when no wait states are configured.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && psel_i && !penable_i) begin
            phase = SETUP;
        end
        addr_o    = (phase == SETUP) ? paddr_i  : addr_q;
        cur_write = (phase == SETUP) ? pwrite_i : write_q;
        cur_err   = addr_o > ADDR_W'(ADDR_TSR);
        finishing = ((phase == SETUP) && (WS == 3'd0)) ||
                    ((phase == ACCESS) && !pready_q && psel_i && (cnt_q == 3'd1));
    end

    assign rd_en_o    = finishing && !cur_write;
    assign wr_en_o    = (state_q == ACCESS) && pready_q && psel_i && write_q;
    assign addr_err_o = cur_err;
    assign wdata_o    = wdata_q;
    assign pready_o   = pready_q;

    // Handshake FSM: latch the transfer in SETUP, count wait states in
    // ACCESS, raise pready for one cycle, abort if psel drops early.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= 8'h00;
            pready_q <= 1'b0;
        end else begin
            pready_q <= finishing;
            case (phase)
                SETUP: begin
                    addr_q  <= paddr_i;
                    write_q <= pwrite_i;
                    wdata_q <= pwdata_i;
                    cnt_q   <= WS;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (pready_q || !psel_i) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TIMER_APB_PSLVERR_EN
    logic pslverr_q;

    // Error response travels alongside pready for out-of-range addresses.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= finishing && cur_err;
        end
    end

    assign pslverr_o = pslverr_q;
`else
    assign pslverr_o = 1'b0;
`endif

endmodule

// File: rtl/timer_apb_slave.sv
// ---------------------------------------------------------------------------
// timer_apb_slave
// APB3 completer for the 8-bit timer register bank: TDR (0x00), TCR (0x01),
// TSR (0x02). Captures overflow/underflow pulses into sticky status bits.
// Optional feature macro: TIMER_APB_PSLVERR_EN (pslverr on illegal address).
//
// Ports:
//   pclk, presetn              clock, asynchronous active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata              APB address / write data
//   prdata, pready, pslverr    APB response
//   tdr, tcr                   configuration to the counter core
//   ovf_set, udf_set           one-cycle status pulses from the counter
//   tsr                        status {6'b0, udf, ovf}
// ---------------------------------------------------------------------------
module timer_apb_slave
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tdr,
    output logic [7:0]        tcr,
    input  logic              ovf_set,
    input  logic              udf_set,
    output logic [7:0]        tsr
);

    logic              wr_en;
    logic              rd_en;
    logic              addr_err;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;

    logic [7:0] tdr_q, tcr_q, prdata_q;
    logic       ovf_q, udf_q;
    logic       ovf_d, udf_d;
    logic       wr_tdr, wr_tcr, wr_tsr;
    logic [7:0] rd_mux;

    timer_apb_fsm #(
        .WAIT_STATES(WAIT_STATES),
        .ADDR_W     (ADDR_W)
    ) u_fsm (
        .pclk_i    (pclk),
        .presetn_i (presetn),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .wr_en_o   (wr_en),
        .rd_en_o   (rd_en),
        .addr_err_o(addr_err),
        .addr_o    (addr),
        .wdata_o   (wdata)
    );

    // Address decode for writes and the read-data mux.
    always_comb begin
        wr_tdr = wr_en && !addr_err && (addr == ADDR_W'(ADDR_TDR));
        wr_tcr = wr_en && !addr_err && (addr == ADDR_W'(ADDR_TCR));
        wr_tsr = wr_en && !addr_err && (addr == ADDR_W'(ADDR_TSR));
        rd_mux = 8'h00;
        if (addr == ADDR_W'(ADDR_TDR)) begin
            rd_mux = tdr_q;
        end else if (addr == ADDR_W'(ADDR_TCR)) begin
            rd_mux = tcr_q;
        end else if (addr == ADDR_W'(ADDR_TSR)) begin
            rd_mux = tsr_pack(udf_q, ovf_q);
        end
    end

    // Status bits: write-0 clears, hardware pulse sets and wins a tie.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~(wr_tsr & ~wdata[OVF]));
        udf_d = udf_set | (udf_q & ~(wr_tsr & ~wdata[UDF]));
    end

    // Register bank and registered read data (zero outside completion).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q    <= 8'h00;
            tcr_q    <= 8'h00;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            prdata_q <= 8'h00;
        end else begin
            if (wr_tdr) begin
                tdr_q <= wdata;
            end
            if (wr_tcr) begin
                tcr_q <= wdata & TCR_MASK;
            end
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            prdata_q <= (rd_en && !addr_err) ? rd_mux : 8'h00;
        end
    end

    assign tdr    = tdr_q;
    assign tcr    = tcr_q;
    assign tsr    = tsr_pack(udf_q, ovf_q);
    assign prdata = prdata_q;

endmodule

// File: doc/timer_apb_slave.md
Name: timer_apb_slave

Overview:
- APB3 responder (completer) for the 8-bit timer register bank. It answers the CPU-model APB initiator used by the timer benches.
- Holds TDR (0x00), TCR (0x01) and TSR (0x02).
- Drives configuration to the counter core and captures overflow/underflow pulses from it into sticky status bits.
- Inserts a configurable number of wait states per transfer; flags illegal addresses.

Parameters:
- WAIT_STATES, 0, number of cycles pready is held low in ACCESS before completion (0..7).
- ADDR_W, 8, width of paddr.

Ports:
- pclk  input  1  APB clock; the single clock of the block.
- presetn  input  1  asynchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (ACCESS phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  register address.
- pwdata  input  8  write data.
- prdata  output  8  read data, valid when pready=1 in ACCESS.
- pready  output  1  transfer-complete.
- pslverr  output  1  error response, valid with pready.
- tdr  output  8  TDR value to counter.
- tcr  output  8  TCR value to counter: [7] load, [5] down(1)/up(0), [4] enable, [1:0] clock select (00 clk2, 01 clk4, 10 clk8, 11 clk16).
- ovf_set  input  1  one-cycle overflow pulse from counter.
- udf_set  input  1  one-cycle underflow pulse from counter.
- tsr  output  8  status: [0] ovf, [1] udf, others 0.

Behaviour:
- Reset (presetn low, async): FSM→IDLE; tdr=0x00, tcr=0x00, tsr=0x00, prdata=0x00, pready=0, pslverr=0.
- FSM states:
  - IDLE: psel=1, penable=0 → SETUP.
  - SETUP: always → ACCESS. Wait counter loaded with WAIT_STATES; address/pwrite/pwdata latched.
  - ACCESS: wait counter>0 → decrement, pready=0. Counter==0 → pready=1 for exactly one cycle and the access commits; next state is IDLE.
  - psel dropped while in ACCESS before completion → abort to IDLE, no commit.
- Latency: WAIT_STATES=0 → pready high in the first ACCESS cycle (2-cycle transfer). Each wait state adds one cycle.
- Writes commit on the pready=1 cycle.
  - TDR: all 8 bits.
  - TCR: mask 0xB3; reserved bits [6],[3],[2] are stored 0.
  - TSR: write-0-to-clear per bit [1:0]; writing 1 has no effect.
- Reads: prdata registered and valid in the pready cycle. TCR reads the masked value; TSR reads {6'b0, udf, ovf}. prdata returns to 0x00 outside completion.
- Status set/clear:
  - ovf_set/udf_set set the bit on the next pclk edge regardless of bus activity.
  - Simultaneous hardware set and software clear of the same bit → set wins (bit = 1).
- Illegal address (paddr > 0x02): no register changes, prdata=0x00.
- Reset mid-transfer: immediate return to reset values; the in-flight write is lost.
- tdr/tcr/tsr outputs are direct register outputs (no extra latency after commit).

Optional Feature:
- TIMER_APB_PSLVERR_EN
  - Defined: pslverr=1 together with pready on an illegal-address access; 0 otherwise.
  - Undefined: pslverr tied 0; illegal accesses complete silently (read 0x00, write ignored).

Decomposition:
- Package timer_pkg: address constants ADDR_TDR=8'h00, ADDR_TCR=8'h01, ADDR_TSR=8'h02; TCR_MASK=8'hB3; TSR bit indices OVF=0, UDF=1; FSM state typedef {IDLE, SETUP, ACCESS}.
- One natural sub-module: timer_apb_fsm (APB handshake and wait-state counter; emits wr_en/rd_en/addr_err strobes). The register bank stays in the top.

Test Plan:
- Reset: presetn low mid-ACCESS → tdr/tcr/tsr/prdata=0x00, pready=0 asynchronously; bus idle afterwards.
- Write TCR 8'h13, read back → prdata=0x13, tcr=0x13; write 8'hFF → read 0xB3.
- ovf_set pulse → read TSR=0x01; write TSR 8'h00 → read TSR=0x00. udf_set → 0x02.
- ovf_set on the same cycle as the committing TSR write 8'h00 → TSR reads 0x01.
- WAIT_STATES=3: pready rises exactly 4 cycles after entering ACCESS; transfer totals 5 cycles; write commits only then.
- Access paddr 8'h05 with TIMER_APB_PSLVERR_EN → pslverr=1, prdata=0x00, registers unchanged. Without the macro → pslverr=0.
